// File: rtl/cordic_pkg.sv
// Shared types for the CORDIC phase sequencer: widths, sequencer states and the
// buffered result record.
package cordic_pkg;

  localparam int ANGLE_W = 16;
  localparam int DATA_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } seq_state_e;

  typedef struct packed {
    logic signed [DATA_W-1:0] sin;
    logic signed [DATA_W-1:0] cos;
    logic [ANGLE_W-1:0]       phase;
  } cordic_sample_t;

endpackage

// File: rtl/cordic_result_fifo.sv
// Small synchronous FIFO of cordic samples. Head entry comes straight from storage
// flops, so nothing on the read side depends combinationally on pop.
module cordic_result_fifo
  import cordic_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  cordic_sample_t push_data,
  input  logic           pop,
  output cordic_sample_t head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  cordic_sample_t   mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_push  = push && (count_q != CNT_W'(DEPTH));
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Zero the head while empty so the stream reads all-zero when not valid.
  assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count = count_q;

endmodule

// File: rtl/cordic_phase_sequencer.sv
// NCO front end for cordic_core: issues one angle per computation, waits out the
// core's busy window and streams the captured sin/cos with the angle that made them.
module cordic_phase_sequencer
  import cordic_pkg::*;
#(
  parameter int ACC_W      = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int WATCHDOG   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [ACC_W-1:0]         ftw,
  input  logic                     ftw_load,
  input  logic [ANGLE_W-1:0]       phase_offset,
  output logic                     cordic_start,
  output logic [ANGLE_W-1:0]       cordic_angle,
  input  logic                     cordic_busy,
  input  logic signed [DATA_W-1:0] cordic_sin,
  input  logic signed [DATA_W-1:0] cordic_cos,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [DATA_W-1:0] m_sin,
  output logic signed [DATA_W-1:0] m_cos,
  output logic [ANGLE_W-1:0]       m_phase,
  output logic                     err_timeout
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int WD_W  = $clog2(WATCHDOG + 1);

  seq_state_e         state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   ftw_reg_q, ftw_reg_d;
  logic [ANGLE_W-1:0] pending_phase_q, pending_phase_d;
  logic [WD_W-1:0]    wd_cnt_q, wd_cnt_d;
  logic               err_q, err_d;

  logic [ANGLE_W-1:0] issue_angle;
  logic [CNT_W:0]     occ_after_push;
  logic               push;
  logic               pop;
  logic [CNT_W-1:0]   fifo_count;
  cordic_sample_t     push_data;
  cordic_sample_t     head;

  assign m_valid = (fifo_count != '0);
  assign pop     = m_valid && m_ready;

  always_comb begin
    state_d         = state_q;
    acc_d           = acc_q;
    ftw_reg_d       = ftw_load ? ftw : ftw_reg_q;
    pending_phase_d = pending_phase_q;
    wd_cnt_d        = wd_cnt_q;
    err_d           = err_q;
    push            = 1'b0;
    cordic_start    = 1'b0;
    cordic_angle    = '0;
    issue_angle     = acc_q[ACC_W-1 -: ANGLE_W] + phase_offset;
    // Occupancy once this cycle's capture and any concurrent pop have landed.
    occ_after_push  = {1'b0, fifo_count} + (CNT_W + 1)'(1) - (CNT_W + 1)'(pop);

    case (state_q)
      IDLE: begin
        // Nothing is in flight here, so the FIFO count alone decides whether a slot is free.
        if (enable && (fifo_count < CNT_W'(FIFO_DEPTH))) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cordic_start    = 1'b1;
        cordic_angle    = issue_angle;
        pending_phase_d = issue_angle;
        acc_d           = acc_q + ftw_reg_q;
        wd_cnt_d        = '0;
        state_d         = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // Timeout lands err_timeout exactly WATCHDOG cycles after the start cycle.
        if (cordic_busy) begin
          state_d = WAIT_DONE;
        end else if (wd_cnt_q == WD_W'(WATCHDOG - 2)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!cordic_busy) begin
          push = 1'b1;
          if (enable && (occ_after_push < (CNT_W + 1)'(FIFO_DEPTH))) begin
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      acc_q           <= '0;
      ftw_reg_q       <= '0;
      pending_phase_q <= '0;
      wd_cnt_q        <= '0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      acc_q           <= acc_d;
      ftw_reg_q       <= ftw_reg_d;
      pending_phase_q <= pending_phase_d;
      wd_cnt_q        <= wd_cnt_d;
      err_q           <= err_d;
    end
  end

  always_comb begin
    push_data       = '0;
    push_data.sin   = cordic_sin;
    push_data.cos   = cordic_cos;
    push_data.phase = pending_phase_q;
  end

  cordic_result_fifo #(
    .DEPTH(FIFO_DEPTH),
    .CNT_W(CNT_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .head     (head),
    .count    (fifo_count)
  );

  assign m_sin       = head.sin;
  assign m_cos       = head.cos;
  assign m_phase     = head.phase;
  assign err_timeout = err_q;

endmodule
